// File: rtl/i2c_knob_scanner.sv
// rtl/i2c_knob_scanner.sv - periodic Avalon-MM ADC channel scanner with hysteresis, timeout and change strobes
module i2c_knob_scanner #(
  parameter int SYS_CLK_FREQ_HZ = 50000000,
  parameter int SCAN_FREQ_HZ    = 100,
  parameter int NUM_CH          = 8,
  parameter int ADDR_WIDTH      = 3,
  parameter int DATA_WIDTH      = 8,
  parameter int KNOB_WIDTH      = 8,
  parameter int HYST            = 1,
  parameter int TIMEOUT_CYCLES  = 100000
) (
  input  logic                           clk_i,
  input  logic                           arst_ni,
  input  logic                           scan_en_i,
  input  logic                           err_clr_i,
  output logic [ADDR_WIDTH-1:0]          amm_address_o,
  output logic                           amm_read_o,
  input  logic [DATA_WIDTH-1:0]          amm_readdata_i,
  input  logic                           amm_readdatavalid_i,
  input  logic                           amm_waitrequest_i,
  output logic [NUM_CH*KNOB_WIDTH-1:0]   knob_level_o,
  output logic [NUM_CH-1:0]              knob_changed_o,
  output logic                           scan_done_o,
  output logic [NUM_CH-1:0]              timeout_err_o
);

  localparam int TICK   = SYS_CLK_FREQ_HZ / SCAN_FREQ_HZ;
  localparam int TICK_W = (TICK > 1) ? $clog2(TICK) : 1;
  localparam int TO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [TICK_W-1:0]     TICK_LAST = TICK_W'(TICK - 1);
  localparam logic [TO_W-1:0]       TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] CH_LAST   = ADDR_WIDTH'(NUM_CH - 1);
  localparam logic [KNOB_WIDTH:0]   HYST_EXT  = (KNOB_WIDTH + 1)'(HYST);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_UPD  = 3'd3;
  localparam logic [2:0] S_NEXT = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  logic [TICK_W-1:0]            tick_cnt_q, tick_cnt_d;
  logic [2:0]                   state_q, state_d;
  logic [ADDR_WIDTH-1:0]        ch_q, ch_d;
  logic [TO_W-1:0]              to_cnt_q, to_cnt_d;
  logic [KNOB_WIDTH-1:0]        sample_q, sample_d;
  logic [NUM_CH*KNOB_WIDTH-1:0] knob_q, knob_d;
  logic [NUM_CH-1:0]            changed_q, changed_d;
  logic [NUM_CH-1:0]            err_q, err_d;
  logic [NUM_CH-1:0]            first_seen_q, first_seen_d;

  logic                  tick;
  logic [NUM_CH-1:0]     ch_oh;
  logic [NUM_CH-1:0]     err_set;
  logic [KNOB_WIDTH-1:0] old_knob;
  logic [KNOB_WIDTH:0]   diff;
  logic                  accept;

  assign tick  = scan_en_i && (tick_cnt_q == TICK_LAST);
  assign ch_oh = NUM_CH'(1) << ch_q;

  always_comb begin
    tick_cnt_d = tick_cnt_q + TICK_W'(1);
    if (!scan_en_i || tick) begin
      tick_cnt_d = '0;
    end
  end

  // Hysteresis on one extra bit so the magnitude never wraps.
  always_comb begin
    old_knob = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_oh[i]) begin
        old_knob = knob_q[i*KNOB_WIDTH +: KNOB_WIDTH];
      end
    end
    if (sample_q > old_knob) begin
      diff = {1'b0, sample_q} - {1'b0, old_knob};
    end else begin
      diff = {1'b0, old_knob} - {1'b0, sample_q};
    end
    accept = ((first_seen_q & ch_oh) == '0) || (diff > HYST_EXT);
  end

  always_comb begin
    state_d      = state_q;
    ch_d         = ch_q;
    to_cnt_d     = to_cnt_q;
    sample_d     = sample_q;
    knob_d       = knob_q;
    changed_d    = '0;
    first_seen_d = first_seen_q;
    err_set      = '0;
    case (state_q)
      S_IDLE: begin
        if (tick) begin
          state_d = S_REQ;
          ch_d    = '0;
        end
      end
      S_REQ: begin
        to_cnt_d = '0;
        if (!amm_waitrequest_i) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (amm_readdatavalid_i) begin
          sample_d = amm_readdata_i[DATA_WIDTH-1 -: KNOB_WIDTH];
          state_d  = S_UPD;
        end else if (to_cnt_q == TO_LAST) begin
          err_set = ch_oh;
          state_d = S_NEXT;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      S_UPD: begin
        first_seen_d = first_seen_q | ch_oh;
        if (accept) begin
          for (int i = 0; i < NUM_CH; i++) begin
            if (ch_oh[i]) begin
              knob_d[i*KNOB_WIDTH +: KNOB_WIDTH] = sample_q;
            end
          end
          changed_d = ch_oh;
        end
        state_d = S_NEXT;
      end
      S_NEXT: begin
        if (ch_q == CH_LAST) begin
          state_d = S_DONE;
        end else begin
          ch_d    = ch_q + ADDR_WIDTH'(1);
          state_d = S_REQ;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // A fresh timeout wins over a simultaneous clear on the same channel.
  assign err_d = (err_q & ~{NUM_CH{err_clr_i}}) | err_set;

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      tick_cnt_q   <= '0;
      state_q      <= S_IDLE;
      ch_q         <= '0;
      to_cnt_q     <= '0;
      sample_q     <= '0;
      knob_q       <= '0;
      changed_q    <= '0;
      err_q        <= '0;
      first_seen_q <= '0;
    end else begin
      tick_cnt_q   <= tick_cnt_d;
      state_q      <= state_d;
      ch_q         <= ch_d;
      to_cnt_q     <= to_cnt_d;
      sample_q     <= sample_d;
      knob_q       <= knob_d;
      changed_q    <= changed_d;
      err_q        <= err_d;
      first_seen_q <= first_seen_d;
    end
  end

  assign amm_read_o     = (state_q == S_REQ);
  assign amm_address_o  = ch_q;
  assign knob_level_o   = knob_q;
  assign knob_changed_o = changed_q;
  assign scan_done_o    = (state_q == S_DONE);
  assign timeout_err_o  = err_q;

endmodule
